// File: rtl/apb_uart_tx.sv
// apb_uart_tx -- 8N1 UART transmitter with an APB completer port.
//
// Software pushes bytes into a small transmit FIFO through the THR register.
// A start/data/stop serialiser drains the FIFO onto tx_o, LSB first, at a
// programmable baud divisor. Each bit lasts max(DIV,1) clock cycles.
//
// Register map (offset = paddr_i[3:2]):
//   0x0 THR  W: push byte (error if the FIFO is full)    R: 0
//   0x4 LSR  R: bit5 THRE (FIFO not full), bit6 TEMT     W: ignored
//   0x8 DIV  R/W: [15:0] baud divisor                     (0 acts as 1)
//   0xC LVL  R: FIFO fill level                           W: ignored
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   psel_i, penable_i,
//   pwrite_i, paddr_i,
//   pwdata_i                APB request
//   prdata_o, pready_o,
//   pslverr_o               APB response (zero wait states)
//   tx_o                    registered serial output, idle high
//   tx_empty_o              registered: FIFO empty and serialiser idle
module apb_uart_tx #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [15:0] DIV_RESET      = 16'd434
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      tx_o,
  output logic                      tx_empty_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // APB decode
  logic       access_s;
  logic       wr_s;
  logic       rd_s;
  logic [1:0] reg_sel_s;
  logic       unused_s;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic [LVL_W-1:0] count_d;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             pop_s;
  logic [7:0]       fifo_rd_s;

  // Divisor and serialiser
  logic [15:0] div_q;
  logic [15:0] div_eff_s;
  logic [15:0] reload_s;
  state_e      state_q;
  state_e      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        bit_end_s;
  logic        tx_q;
  logic        tx_d;
  logic        tx_empty_q;
  logic        tx_empty_d;
  logic        thre_s;
  logic        temt_s;

  assign access_s  = psel_i & penable_i;
  assign wr_s      = access_s & pwrite_i;
  assign rd_s      = access_s & ~pwrite_i;
  assign reg_sel_s = paddr_i[3:2];

  // Address bits outside [3:2] and the upper write-data half carry no meaning.
  assign unused_s = ^{paddr_i[APB_ADDR_WIDTH-1:4], paddr_i[1:0], pwdata_i[31:16]};

  assign fifo_full_s  = (count_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty_s = (count_q == {LVL_W{1'b0}});
  // Fullness is judged on the registered level, so a same-cycle pop cannot rescue a push.
  assign push_s       = wr_s & (reg_sel_s == 2'd0) & ~fifo_full_s;
  assign fifo_rd_s    = mem_q[rd_ptr_q];

  assign div_eff_s = (div_q == 16'd0) ? 16'd1 : div_q;
  assign reload_s  = div_eff_s - 16'd1;
  assign bit_end_s = (cnt_q == 16'd0);

  assign thre_s = ~fifo_full_s;
  assign temt_s = fifo_empty_s & (state_q == ST_IDLE);

  assign pready_o   = 1'b1;
  assign pslverr_o  = wr_s & (reg_sel_s == 2'd0) & fifo_full_s;
  assign tx_o       = tx_q;
  assign tx_empty_o = tx_empty_q;

  // Register read mux, combinational from current state.
  always_comb begin
    prdata_o = 32'd0;
    if (rd_s) begin
      case (reg_sel_s)
        2'd0:    prdata_o = 32'd0;
        2'd1:    prdata_o = {25'd0, temt_s, thre_s, 5'd0};
        2'd2:    prdata_o = {16'd0, div_q};
        2'd3:    prdata_o = {{(32-LVL_W){1'b0}}, count_q};
        default: prdata_o = 32'd0;
      endcase
    end else begin
      prdata_o = 32'd0;
    end
  end

  // FIFO level next-state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1'b1);
      2'b01:   count_d = count_q - LVL_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= pwdata_i[7:0];
    end
  end

  // FIFO pointers, level and baud divisor register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {LVL_W{1'b0}};
      div_q    <= DIV_RESET;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
      end
      count_q <= count_d;
      if (wr_s && (reg_sel_s == 2'd2)) begin
        div_q <= pwdata_i[15:0];
      end
    end
  end

  // Serialiser next-state. The bit counter is reloaded from the live divisor at
  // every bit boundary, so divisor writes take effect at the next bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rd_s;
          cnt_d   = reload_s;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_d   = reload_s;
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = reload_s;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d = reload_s;
          // Chain straight into the next frame when more data is waiting.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_rd_s;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level for the current state; registered one cycle later onto tx_o.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    tx_empty_d = temt_s;
  end

  // Serialiser state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      tx_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_empty_q <= tx_empty_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
module tb_apb_uart_tx;

  localparam int HN = 32768;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic        tx_o;
  logic        tx_empty_o;

  apb_uart_tx #(
    .APB_ADDR_WIDTH(32),
    .FIFO_DEPTH    (8),
    .DIV_RESET     (16'd434)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .tx_o      (tx_o),
    .tx_empty_o(tx_empty_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  // Line history, one entry per falling edge.
  logic hist_tx [HN];
  logic hist_em [HN];
  int   ncyc = 0;

  always @(negedge clk_i) begin
    if (ncyc < HN) begin
      hist_tx[ncyc] <= tx_o;
      hist_em[ncyc] <= tx_empty_o;
    end
    ncyc <= ncyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic hbit_tx(input int i);
    if (i >= 0 && i < HN && i < ncyc) return hist_tx[i];
    else return 1'bx;
  endfunction

  function automatic logic hbit_em(input int i);
    if (i >= 0 && i < HN && i < ncyc) return hist_em[i];
    else return 1'bx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = addr; pwdata_i = data;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(negedge clk_i);
    err = pslverr_o;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = addr;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(negedge clk_i);
    data = prdata_o;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic write_chk(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic err;
    apb_write(addr, data, err);
    check(tag, {31'd0, err}, 32'd0);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    check(tag, d, exp);
  endtask

  // Push a byte through THR and record it on the scoreboard.
  task automatic send_byte(input logic [7:0] b);
    write_chk("thr_wr_err", 32'h0, {24'd0, b});
    sb_q.push_back(b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(negedge clk_i);
    while (tx_empty_o !== 1'b1 && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_timeout", {31'd0, n < 20000}, 32'd1);
    repeat (2) @(posedge clk_i);
  endtask

  task automatic find_start(input int from, output int s);
    s = -1;
    for (int i = from; i < ncyc && i < HN; i++) begin
      if (hist_tx[i] === 1'b0) begin
        s = i;
        break;
      end
    end
  endtask

  // Pop the expected byte and compare the logged frame cycle by cycle. Bits with
  // index below sw (0 = start, 1..8 data, 9 stop) last len_pre, the rest len_post.
  task automatic decode(input string tag, input int s, input int len_pre, input int len_post,
                        input int sw, output int e);
    logic [7:0] expb;
    logic [7:0] got;
    logic       eb;
    logic       ob;
    int         mism;
    int         idx;
    int         len;
    check({tag, "_sb_nz"}, {31'd0, sb_q.size() != 0}, 32'd1);
    expb = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
    got  = 8'h00;
    mism = 0;
    idx  = s;
    for (int k = 0; k < 10; k++) begin
      len = (k < sw) ? len_pre : len_post;
      for (int j = 0; j < len; j++) begin
        eb = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : expb[k-1]);
        ob = hbit_tx(idx);
        if (ob !== eb) mism++;
        if (j == len / 2 && k >= 1 && k <= 8) got[k-1] = ob;
        idx++;
      end
    end
    check({tag, "_cycles"}, mism, 32'd0);
    check({tag, "_byte"}, {24'd0, got}, {24'd0, expb});
    e = idx;
  endtask

  initial begin
    int m, s, e, s2, e2, r0;
    logic err;

    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = 32'd0; pwdata_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state and idle bus
    @(negedge clk_i);
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_empty", {31'd0, tx_empty_o}, 32'd1);
    check("pready", {31'd0, pready_o}, 32'd1);
    check("idle_prdata", prdata_o, 32'd0);
    check("idle_pslverr", {31'd0, pslverr_o}, 32'd0);
    read_chk("rst_lsr", 32'h4, 32'h60);
    read_chk("rst_div", 32'h8, 32'd434);
    read_chk("rst_lvl", 32'hC, 32'd0);
    read_chk("rst_thr", 32'h0, 32'd0);
    write_chk("lsr_wr_err", 32'h4, 32'hFFFF_FFFF);

    // Single byte, DIV=4: latency, waveform, TEMT timing
    write_chk("div4_wr", 32'h8, 32'd4);
    send_byte(8'h55);
    m = ncyc;
    wait_idle();
    find_start(m, s);
    check("f55_latency", s, m + 2);
    decode("f55", s, 4, 4, 10, e);
    check("f55_empty_before", {31'd0, hbit_em(s + 39)}, 32'd0);
    check("f55_empty_at", {31'd0, hbit_em(s + 40)}, 32'd1);

    // Back-to-back frames, DIV=2
    write_chk("div2_wr", 32'h8, 32'd2);
    send_byte(8'hA5);
    m = ncyc;
    send_byte(8'h3C);
    read_chk("b2b_lvl1", 32'hC, 32'd1);
    repeat (20) @(posedge clk_i);
    read_chk("b2b_lvl0", 32'hC, 32'd0);
    wait_idle();
    find_start(m, s);
    check("fa5_latency", s, m + 2);
    decode("fa5", s, 2, 2, 10, e);
    find_start(e, s2);
    check("f3c_nogap", s2, e);
    decode("f3c", s2, 2, 2, 10, e2);

    // Fill: one byte goes to the shifter, eight sit in the FIFO, next is rejected
    write_chk("div100_wr", 32'h8, 32'd100);
    m = ncyc;
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
    read_chk("full_lvl", 32'hC, 32'd8);
    read_chk("full_lsr", 32'h4, 32'h00);
    apb_write(32'h0, 32'h0000_00EE, err);
    check("ovf_pslverr", {31'd0, err}, 32'd1);
    wait_idle();
    find_start(m, s);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        find_start(e, s);
        check("fill_nogap", s, e);
      end
      decode("fill", s, 100, 100, 10, e);
    end
    find_start(e, s);
    check("ovf_never_sent", s, -1);
    check("fill_sb_drained", sb_q.size(), 32'd0);

    // DIV=0 behaves as 1
    write_chk("div0_wr", 32'h8, 32'd0);
    read_chk("div0_rd", 32'h8, 32'd0);
    send_byte(8'hFF);
    m = ncyc;
    wait_idle();
    find_start(m, s);
    check("fff_latency", s, m + 2);
    decode("fff", s, 1, 1, 10, e);
    check("fff_empty_before", {31'd0, hbit_em(s + 9)}, 32'd0);
    check("fff_empty_at", {31'd0, hbit_em(s + 10)}, 32'd1);

    // DIV 4 -> 8 written while data bit 3 is on the line
    write_chk("div4b_wr", 32'h8, 32'd4);
    send_byte(8'h96);
    m = ncyc;
    repeat (17) @(negedge clk_i);
    write_chk("div8_wr", 32'h8, 32'd8);
    wait_idle();
    find_start(m, s);
    check("f96_latency", s, m + 2);
    decode("f96", s, 4, 8, 5, e);
    check("f96_empty_before", {31'd0, hbit_em(s + 59)}, 32'd0);
    check("f96_empty_at", {31'd0, hbit_em(s + 60)}, 32'd1);

    // Reset during data bit 5 with three bytes queued
    write_chk("div4c_wr", 32'h8, 32'd4);
    send_byte(8'h01);
    m = ncyc;
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    read_chk("rst_mid_lvl3", 32'hC, 32'd3);
    s = m + 2;
    while (ncyc < s + 26) @(posedge clk_i);
    check("rst_mid_bit5_low", {31'd0, hbit_tx(s + 25)}, 32'd0);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_mid_tx", {31'd0, tx_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    sb_q.delete();
    r0 = ncyc;
    read_chk("rst_mid_lvl", 32'hC, 32'd0);
    read_chk("rst_mid_lsr", 32'h4, 32'h60);
    read_chk("rst_mid_div", 32'h8, 32'd434);
    check("rst_mid_empty", {31'd0, tx_empty_o}, 32'd1);
    repeat (300) @(posedge clk_i);
    find_start(r0, s);
    check("rst_no_resume", s, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
